src_control_sequencer: RTL and testbench
========================================

# src_control_sequencer

Hardwired control-step sequencer for the SRC datapath. It generates the Gra/Grb/Grc/Rin/Rout/BAout strobes that the select-and-encode block decodes into per-register enables, plus the PC, MAR, MDR, IR, Y and Z strobes, memory Read/Write and the ALU op. It walks fetch T0–T2 and per-opcode execute steps, stalls on a memory-ready handshake, and stops on halt.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-low reset; one clock, synchronous reset, active-low
- opcode  in  5  IR[31:27]; sampled only in T3
- mem_ready  in  1  memory completes Read/Write this cycle
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  select/encode strobes; Cout drives sign-extended C onto bus
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout  out  1 each  datapath strobes
- Read, Write  out  1 each  memory strobes
- alu_op  out  5  ALU operation code; 5'b00000 when Zin=0
- run  out  1  1 = executing, 0 = halted

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, nop 11001, halt 11010. Any other opcode executes as nop.
- States: IDLE, T0–T7, HALT. Outputs are Moore-decoded from state and opcode latched at T3. Unlisted outputs are 0.
- IDLE: run=1, no strobes. Next state is T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0. Moves to T2 on mem_ready=1.
- T2: MDRout, IRin. Next state is T3.
- T3 latches opcode:
  - nop → T0.
  - halt → HALT.
  - reg-reg ALU (add/sub/and/or): Grb, Rout, Yin.
  - immediate (addi/andi/ori/ldi/ld/st): Grb, BAout, Yin.
- T4:
  - reg-reg: Grc, Rout, Zin, alu_op=opcode.
  - immediate ALU: Cout, Zin, alu_op=opcode.
  - ldi/ld/st: Cout, Zin, alu_op=00011.
- T5:
  - ALU/ldi: Zlowout, Gra, Rin, then → T0.
  - ld/st: Zlowout, MARin.
- T6:
  - ld: Read, MDRin. Stalls until mem_ready=1.
  - st: Gra, Rout, MDRin (Read=0 selects bus into MDR).
- T7:
  - ld: MDRout, Gra, Rin, then → T0.
  - st: Write. Stalls until mem_ready=1, then → T0.
- HALT: run=0, all strobes 0. Stays in HALT until clear.
- Read and Write are never asserted together. Exactly one of Gra/Grb/Grc is high whenever Rin, Rout or BAout is high.
- alu_op is 00011 for immediate address arithmetic and equals opcode for ALU ops.

## Timing
- clear=0 at an edge puts the state in IDLE. From the next cycle all strobes are 0 and run=1. This holds from any state, including during a stalled T1/T6/T7 and from HALT.
- mem_ready is sampled at the edge that ends T1/T6/T7. With mem_ready=1 in the first cycle, each memory step takes 1 cycle; each cycle of mem_ready=0 adds 1 cycle. Strobes are held constant during a stall, and repeated PCin/MDRin are idempotent.
- mem_ready is ignored in all other states.
- Instruction length with zero wait:
  - nop: 4 cycles.
  - ALU and ldi: 6 cycles.
  - ld and st: 8 cycles.
- The first T0 follows IDLE, so the first fetch starts 1 cycle after clear is released.
- opcode changes outside T3 have no effect.

## Test plan
- Reset: clear=0 for 2 cycles in mid-T4 → IDLE, all strobes 0, run=1. Release → T0 next cycle with PCout=MARin=IncPC=Zin=1.
- add (00011), mem_ready=1: T3 has Grb,Rout,Yin. T4 has Grc,Rout,Zin,alu_op=00011. T5 has Zlowout,Gra,Rin. T0 is reached 6 cycles after the previous T0.
- andi (01100): T3 has BAout, not Rout. T4 has Cout,Zin,alu_op=01100. Rin occurs exactly once, in T5.
- ld, mem_ready low 2 cycles in T1 and 3 in T6: T1 lasts 3 cycles and T6 lasts 4, with Read/MDRin held. T7 has MDRout,Gra,Rin. Total is 13 cycles.
- st, mem_ready=0 for 1 cycle in T7: T6 has Gra,Rout,MDRin with Read=0. Write is held 2 cycles, then T0. Read and Write are never both 1.
- halt (11010) then opcode=add: after T3, HALT with run=0 and strobes 0 for 20 cycles. clear=0 for 1 cycle → IDLE then T0.

Source files
------------

// File: rtl/src_control_sequencer_if.sv
// Control-strobe bundle between the SRC control sequencer and the datapath.
// The master modport belongs to the sequencer; the slave side drives opcode and mem_ready.
interface src_control_sequencer_if;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic       Read, Write;
  logic [4:0] alu_op;
  logic       run;

  modport master (
    input  opcode, mem_ready,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
    output Read, Write, alu_op, run
  );

  modport slave (
    output opcode, mem_ready,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
    input  Read, Write, alu_op, run
  );
endinterface

// File: rtl/src_control_sequencer.sv
// Hardwired SRC control-step sequencer: fetch T0-T2, per-opcode execute T3-T7,
// memory-ready stalls in T1/T6/T7 and a sticky HALT state.
module src_control_sequencer (
  input  logic                           clock,
  input  logic                           clear,
  src_control_sequencer_if.master        bus
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [4:0] OP_NOP  = 5'b11001;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     r_state;
  logic [4:0] r_op;

  logic [4:0] w_op;
  logic       w_rr, w_imm, w_ldi, w_ld, w_st, w_halt, w_addr;

  // T3 decodes the live opcode; later steps use the copy captured at the end of T3.
  assign w_op   = (r_state == S_T3) ? bus.opcode : r_op;
  assign w_rr   = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
  assign w_imm  = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
  assign w_ldi  = (w_op == OP_LDI);
  assign w_ld   = (w_op == OP_LD);
  assign w_st   = (w_op == OP_ST);
  assign w_halt = (w_op == OP_HALT);
  assign w_addr = w_ldi || w_ld || w_st;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
    end else begin
      if (r_state == S_T3) r_op <= bus.opcode;
      case (r_state)
        S_IDLE: r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= bus.mem_ready ? S_T2 : S_T1;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_halt)               r_state <= S_HALT;
          else if (w_rr || w_imm || w_addr) r_state <= S_T4;
          else                      r_state <= S_T0;
        end
        S_T4:   r_state <= S_T5;
        S_T5:   r_state <= (w_ld || w_st) ? S_T6 : S_T0;
        S_T6: begin
          if (w_st || bus.mem_ready) r_state <= S_T7;
          else                       r_state <= S_T6;
        end
        S_T7: begin
          if (w_ld || bus.mem_ready) r_state <= S_T0;
          else                       r_state <= S_T7;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore strobe decode from step and opcode class.
  always_comb begin
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.PCout   = 1'b0;
    bus.PCin    = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.alu_op  = 5'b00000;
    bus.run     = (r_state != S_HALT);
    case (r_state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (w_rr) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (w_imm || w_addr) begin
          bus.Grb   = 1'b1;
          bus.BAout = 1'b1;
          bus.Yin   = 1'b1;
        end
      end
      S_T4: begin
        bus.Zin = 1'b1;
        if (w_rr) begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.alu_op = w_op;
        end else if (w_imm) begin
          bus.Cout   = 1'b1;
          bus.alu_op = w_op;
        end else begin
          bus.Cout   = 1'b1;
          bus.alu_op = OP_ADD;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (w_ld || w_st) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (w_st) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
        end else begin
          bus.Read = 1'b1;
        end
      end
      S_T7: begin
        if (w_st) begin
          bus.Write = 1'b1;
        end else begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_src_control_sequencer.sv
// Directed bench for the SRC control sequencer: per-cycle strobe vectors compared
// against hand-written expectations for each instruction class.
module tb_src_control_sequencer;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  src_control_sequencer_if bus ();

  src_control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // Output vector layout: {alu_op[4:0], Gra..Write, run}
  localparam logic [24:0] GRA    = 25'd1 << 19;
  localparam logic [24:0] GRB    = 25'd1 << 18;
  localparam logic [24:0] GRC    = 25'd1 << 17;
  localparam logic [24:0] RIN    = 25'd1 << 16;
  localparam logic [24:0] ROUT   = 25'd1 << 15;
  localparam logic [24:0] BAOUT  = 25'd1 << 14;
  localparam logic [24:0] COUT   = 25'd1 << 13;
  localparam logic [24:0] PCOUT  = 25'd1 << 12;
  localparam logic [24:0] PCIN   = 25'd1 << 11;
  localparam logic [24:0] INCPC  = 25'd1 << 10;
  localparam logic [24:0] MARIN  = 25'd1 << 9;
  localparam logic [24:0] MDRIN  = 25'd1 << 8;
  localparam logic [24:0] MDROUT = 25'd1 << 7;
  localparam logic [24:0] IRIN   = 25'd1 << 6;
  localparam logic [24:0] YIN    = 25'd1 << 5;
  localparam logic [24:0] ZIN    = 25'd1 << 4;
  localparam logic [24:0] ZLOW   = 25'd1 << 3;
  localparam logic [24:0] READ   = 25'd1 << 2;
  localparam logic [24:0] WRITE  = 25'd1 << 1;
  localparam logic [24:0] RUN    = 25'd1;

  localparam logic [24:0] E_T0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [24:0] E_T1 = ZLOW | PCIN | READ | MDRIN | RUN;
  localparam logic [24:0] E_T2 = MDROUT | IRIN | RUN;

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [24:0] aop(input logic [4:0] op);
    return {op, 20'd0};
  endfunction

  function automatic logic [24:0] outs();
    return {bus.alu_op, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
            bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Zin, bus.Zlowout, bus.Read, bus.Write, bus.run};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; bus.opcode = OP_ADD; bus.mem_ready = 1'b1;
    step(); step(); #1;
    n_total++;
    if (outs() !== RUN) $display("FAIL reset_idle: got %h exp %h", outs(), RUN); else n_pass++;
    clear = 1'b1;
    step(); #1;
    n_total++;
    if (outs() !== E_T0) $display("FAIL reset_release_t0: got %h exp %h", outs(), E_T0); else n_pass++;
    step(); step(); step(); step(); #1;
    n_total++;
    if (outs() !== (GRC | ROUT | ZIN | aop(OP_ADD) | RUN))
      $display("FAIL reset_pre_t4: got %h exp %h", outs(), GRC | ROUT | ZIN | aop(OP_ADD) | RUN);
    else n_pass++;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      n_total++;
      if (outs() !== RUN) $display("FAIL reset_mid_t4 cyc %0d: got %h exp %h", i, outs(), RUN); else n_pass++;
    end
    clear = 1'b1;
    step(); #1;
    n_total++;
    if (outs() !== E_T0) $display("FAIL reset_mid_t4_release: got %h exp %h", outs(), E_T0); else n_pass++;
    // Reset during a stalled fetch read.
    bus.mem_ready = 1'b0;
    step(); step(); #1;
    n_total++;
    if (outs() !== E_T1) $display("FAIL reset_stall_t1: got %h exp %h", outs(), E_T1); else n_pass++;
    clear = 1'b0;
    step(); #1;
    n_total++;
    if (outs() !== RUN) $display("FAIL reset_from_stall: got %h exp %h", outs(), RUN); else n_pass++;
    clear = 1'b1; bus.mem_ready = 1'b1;
    step(); #1;
    n_total++;
    if (outs() !== E_T0) $display("FAIL reset_stall_release: got %h exp %h", outs(), E_T0); else n_pass++;
  endtask

  task automatic test_add();
    logic [24:0] ex [7];
    ex = '{E_T0, E_T1, E_T2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | aop(OP_ADD) | RUN,
           ZLOW | GRA | RIN | RUN, E_T0};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = OP_ADD; bus.mem_ready = 1'b1; #1;
      n_total++;
      if (outs() !== ex[i]) $display("FAIL add cyc %0d: got %h exp %h", i, outs(), ex[i]); else n_pass++;
      if (i < 6) step();
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0] ops  [6];
    logic       isrr [6];
    logic [4:0] alu  [6];
    logic [24:0] ex  [7];
    ops  = '{OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ORI, OP_LDI};
    isrr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    alu  = '{5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b01101, 5'b00011};
    for (int k = 0; k < 6; k++) begin
      ex[0] = E_T0; ex[1] = E_T1; ex[2] = E_T2;
      ex[3] = isrr[k] ? (GRB | ROUT | YIN | RUN) : (GRB | BAOUT | YIN | RUN);
      ex[4] = (isrr[k] ? (GRC | ROUT) : COUT) | ZIN | aop(alu[k]) | RUN;
      ex[5] = ZLOW | GRA | RIN | RUN;
      ex[6] = E_T0;
      for (int i = 0; i < 7; i++) begin
        bus.opcode = ops[k]; bus.mem_ready = 1'b1; #1;
        n_total++;
        if (outs() !== ex[i])
          $display("FAIL alu_op %b cyc %0d: got %h exp %h", ops[k], i, outs(), ex[i]);
        else n_pass++;
        if (i < 6) step();
      end
    end
  endtask

  task automatic test_andi();
    logic [24:0] ex [7];
    int rin_cnt;
    rin_cnt = 0;
    ex = '{E_T0, E_T1, E_T2, GRB | BAOUT | YIN | RUN, COUT | ZIN | aop(OP_ANDI) | RUN,
           ZLOW | GRA | RIN | RUN, E_T0};
    for (int i = 0; i < 7; i++) begin
      // Opcode is only meaningful in T3; drive halt everywhere else.
      bus.opcode = (i == 3) ? OP_ANDI : OP_HALT; bus.mem_ready = 1'b1; #1;
      if (bus.Rin) rin_cnt++;
      n_total++;
      if (outs() !== ex[i]) $display("FAIL andi cyc %0d: got %h exp %h", i, outs(), ex[i]); else n_pass++;
      if (i < 6) step();
    end
    n_total++;
    if (rin_cnt !== 1) $display("FAIL andi_rin_count: got %0d exp 1", rin_cnt); else n_pass++;
  endtask

  task automatic test_nop();
    logic [4:0]  ops [2];
    logic [24:0] ex  [5];
    ops = '{OP_NOP, 5'b11111};
    ex  = '{E_T0, E_T1, E_T2, RUN, E_T0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        bus.opcode = ops[k]; bus.mem_ready = (i == 2) ? 1'b0 : 1'b1; #1;
        n_total++;
        if (outs() !== ex[i])
          $display("FAIL nop %b cyc %0d: got %h exp %h", ops[k], i, outs(), ex[i]);
        else n_pass++;
        if (i < 4) step();
      end
    end
  endtask

  task automatic test_ld();
    logic [24:0] ex [14];
    logic        mr [14];
    logic [24:0] e6;
    e6 = READ | MDRIN | RUN;
    ex = '{E_T0, E_T1, E_T1, E_T1, E_T2, GRB | BAOUT | YIN | RUN,
           COUT | ZIN | aop(OP_ADD) | RUN, ZLOW | MARIN | RUN, e6, e6, e6, e6,
           MDROUT | GRA | RIN | RUN, E_T0};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      bus.opcode = OP_LD; bus.mem_ready = mr[i]; #1;
      n_total++;
      if (outs() !== ex[i]) $display("FAIL ld cyc %0d: got %h exp %h", i, outs(), ex[i]); else n_pass++;
      if (i < 13) step();
    end
  endtask

  task automatic test_st();
    logic [24:0] ex [10];
    logic        mr [10];
    int both;
    both = 0;
    ex = '{E_T0, E_T1, E_T2, GRB | BAOUT | YIN | RUN, COUT | ZIN | aop(OP_ADD) | RUN,
           ZLOW | MARIN | RUN, GRA | ROUT | MDRIN | RUN, WRITE | RUN, WRITE | RUN, E_T0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      bus.opcode = OP_ST; bus.mem_ready = mr[i]; #1;
      if (bus.Read && bus.Write) both++;
      n_total++;
      if (outs() !== ex[i]) $display("FAIL st cyc %0d: got %h exp %h", i, outs(), ex[i]); else n_pass++;
      if (i < 9) step();
    end
    n_total++;
    if (both !== 0) $display("FAIL st_read_write_overlap: got %0d exp 0", both); else n_pass++;
  endtask

  task automatic test_halt();
    logic [24:0] ex [24];
    ex[0] = E_T0; ex[1] = E_T1; ex[2] = E_T2; ex[3] = RUN;
    for (int i = 4; i < 24; i++) ex[i] = 25'd0;
    for (int i = 0; i < 24; i++) begin
      bus.opcode = (i <= 3) ? OP_HALT : OP_ADD; bus.mem_ready = 1'(i % 2); #1;
      n_total++;
      if (outs() !== ex[i]) $display("FAIL halt cyc %0d: got %h exp %h", i, outs(), ex[i]); else n_pass++;
      if (i < 23) step();
    end
    clear = 1'b0;
    step(); #1;
    n_total++;
    if (outs() !== RUN) $display("FAIL halt_clear_idle: got %h exp %h", outs(), RUN); else n_pass++;
    clear = 1'b1;
    step(); #1;
    n_total++;
    if (outs() !== E_T0) $display("FAIL halt_clear_t0: got %h exp %h", outs(), E_T0); else n_pass++;
  endtask

  initial begin
    clear = 1'b0;
    bus.opcode = OP_NOP;
    bus.mem_ready = 1'b1;
    test_reset();
    test_add();
    test_alu_ops();
    test_andi();
    test_nop();
    test_ld();
    test_st();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
